// File: rtl/harness_pkg.sv
// Shared helpers and output-FSM encoding for the harness serdes controller.
package harness_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } out_state_e;

    // Smallest r such that 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/harness_lane_parity.sv
// Per-lane running XOR accumulator; clear and reset take priority over accumulate.
module harness_lane_parity #(
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [LANES-1:0] bits_i,
    output logic [LANES-1:0] parity_o
);

    logic [LANES-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ bits_i;
        end
    end

    assign parity_o = acc_q;

endmodule

// File: rtl/harness_serdes_ctrl.sv
// Multi-lane deserialiser/serialiser between FPGA test pins and a wide-port core.
// Define HARNESS_PARITY_EN to add a trailing per-lane even-parity beat to every frame.
module harness_serdes_ctrl
    import harness_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 412,
    parameter int unsigned OUT_WIDTH = 819,
    parameter int unsigned LANES     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES-1:0]     test_i,
    input  logic                 test_valid_i,
    output logic [IN_WIDTH-1:0]  word_o,
    output logic                 word_o_valid,
    input  logic [OUT_WIDTH-1:0] word_i,
    input  logic                 word_i_valid,
    output logic                 word_i_ready,
    output logic [LANES-1:0]     test_o,
    output logic                 test_frame_o,
    output logic                 err_o
);

    localparam int unsigned IN_BEATS  = ceil_div(IN_WIDTH, LANES);
    localparam int unsigned OUT_BEATS = ceil_div(OUT_WIDTH, LANES);
    localparam int unsigned IN_PAD    = IN_BEATS * LANES;
    localparam int unsigned OUT_PAD   = OUT_BEATS * LANES;
    localparam int unsigned IN_CW     = clog2(IN_BEATS + 1);
    localparam int unsigned OUT_CW    = clog2(OUT_BEATS + 1);
    localparam int unsigned OUT_ALIGN = OUT_PAD - OUT_WIDTH;
`ifdef HARNESS_PARITY_EN
    localparam int unsigned PAR_BEATS = 1;
`else
    localparam int unsigned PAR_BEATS = 0;
`endif
    localparam logic [IN_CW-1:0]  IN_LAST       = IN_CW'(IN_BEATS + PAR_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST      = OUT_CW'(OUT_BEATS + PAR_BEATS - 1);
    localparam logic [OUT_CW-1:0] OUT_DATA_LAST = OUT_CW'(OUT_BEATS - 1);

    // Input path state
    logic [IN_PAD-1:0]    in_shreg_q, in_shreg_d, in_shifted_c;
    logic [IN_CW-1:0]     in_cnt_q, in_cnt_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;
    logic                 word_valid_q, word_valid_d;

    // Output path state
    out_state_e           state_q, state_d;
    logic [OUT_PAD-1:0]   out_shreg_q, out_shreg_d, out_shifted_c, out_load_c;
    logic [OUT_CW-1:0]    out_cnt_q, out_cnt_d;
    logic [LANES-1:0]     test_o_q, test_o_d;
    logic                 frame_q, frame_d;
    logic                 ready_q, ready_d;

`ifdef HARNESS_PARITY_EN
    logic                 err_q, err_d;
    logic                 in_par_en_c, in_par_clr_c;
    logic [LANES-1:0]     in_par_c;
    logic                 out_par_en_c, out_par_clr_c;
    logic [LANES-1:0]     out_par_c;

    harness_lane_parity #(.LANES(LANES)) u_in_parity (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (in_par_clr_c),
        .en_i     (in_par_en_c),
        .bits_i   (test_i),
        .parity_o (in_par_c)
    );

    // Outgoing parity follows the beats as they appear on test_o.
    assign out_par_en_c  = (state_q == SHIFT) && (out_cnt_q != OUT_LAST);
    assign out_par_clr_c = (state_q == SHIFT) && (out_cnt_q == OUT_LAST);

    harness_lane_parity #(.LANES(LANES)) u_out_parity (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (out_par_clr_c),
        .en_i     (out_par_en_c),
        .bits_i   (test_o_q),
        .parity_o (out_par_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Input deserialiser: counter-driven, word_o only changes at frame end.
    always_comb begin
        in_shreg_d   = in_shreg_q;
        in_cnt_d     = in_cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        in_shifted_c = (in_shreg_q << LANES) | IN_PAD'(test_i);
`ifdef HARNESS_PARITY_EN
        err_d        = err_q;
        in_par_en_c  = 1'b0;
        in_par_clr_c = 1'b0;
        if (test_valid_i) begin
            if (in_cnt_q == IN_LAST) begin
                word_d       = in_shreg_q[IN_WIDTH-1:0];
                in_cnt_d     = '0;
                in_par_clr_c = 1'b1;
                if (test_i != in_par_c) begin
                    err_d = 1'b1;
                end else begin
                    word_valid_d = 1'b1;
                end
            end else begin
                in_shreg_d  = in_shifted_c;
                in_cnt_d    = in_cnt_q + 1'b1;
                in_par_en_c = 1'b1;
            end
        end
`else
        if (test_valid_i) begin
            in_shreg_d = in_shifted_c;
            if (in_cnt_q == IN_LAST) begin
                word_d       = in_shifted_c[IN_WIDTH-1:0];
                in_cnt_d     = '0;
                word_valid_d = 1'b1;
            end else begin
                in_cnt_d = in_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_shreg_q   <= '0;
            in_cnt_q     <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            in_shreg_q   <= in_shreg_d;
            in_cnt_q     <= in_cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    // Output serialiser FSM: outputs are registered one beat ahead of the shift.
    assign out_load_c    = OUT_PAD'(word_i) << OUT_ALIGN;
    assign out_shifted_c = out_shreg_q << LANES;

    always_comb begin
        state_d     = state_q;
        out_shreg_d = out_shreg_q;
        out_cnt_d   = out_cnt_q;
        test_o_d    = '0;
        frame_d     = 1'b0;
        ready_d     = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (word_i_valid) begin
                    state_d     = SHIFT;
                    out_shreg_d = out_load_c;
                    out_cnt_d   = '0;
                    test_o_d    = out_load_c[OUT_PAD-1 -: LANES];
                    frame_d     = 1'b1;
                    ready_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (out_cnt_q == OUT_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    out_shreg_d = out_shifted_c;
                    out_cnt_d   = out_cnt_q + 1'b1;
                    test_o_d    = out_shifted_c[OUT_PAD-1 -: LANES];
                    frame_d     = 1'b1;
`ifdef HARNESS_PARITY_EN
                    if (out_cnt_q == OUT_DATA_LAST) begin
                        test_o_d = test_o_q ^ out_par_c;
                    end
`else
                    if (out_cnt_q == OUT_DATA_LAST) begin
                        test_o_d = '0;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_shreg_q <= '0;
            out_cnt_q   <= '0;
            test_o_q    <= '0;
            frame_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            out_shreg_q <= out_shreg_d;
            out_cnt_q   <= out_cnt_d;
            test_o_q    <= test_o_d;
            frame_q     <= frame_d;
            ready_q     <= ready_d;
        end
    end

    assign word_o       = word_q;
    assign word_o_valid = word_valid_q;
    assign word_i_ready = ready_q;
    assign test_o       = test_o_q;
    assign test_frame_o = frame_q;

endmodule

// File: doc/harness_serdes_ctrl.md
Name: harness_serdes_ctrl

Overview:
Parametrised successor to the single-lane synthesis harness pair used in FPGA wrappers. It deserialises a multi-lane test stream into a wide DUT input word and serialises a wide DUT output word back out. Unlike the free-running harness, it has frame counters, valid/ready handshakes and explicit frame markers, so DUT inputs update only on complete frames. It sits between the FPGA test pins and any wide-port core, such as a point multiplier, inside a *_wrapper module.

Parameters:
IN_WIDTH, 412, width of the deserialised word presented to the DUT
OUT_WIDTH, 819, width of the DUT word to serialise
LANES, 1, number of parallel serial lanes in each direction (1..32)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
test_i  input  LANES  serial input lanes
test_valid_i  input  1  input beat qualifier; when low, input shifting stalls
word_o  output  IN_WIDTH  last complete deserialised word
word_o_valid  output  1  one-cycle pulse when word_o updates
word_i  input  OUT_WIDTH  DUT result word
word_i_valid  input  1  result offered for serialisation
word_i_ready  output  1  serialiser idle and able to accept word_i
test_o  output  LANES  serial output lanes
test_frame_o  output  1  high on every beat carrying output frame data
err_o  output  1  sticky parity error (only with the optional feature)

Behaviour:
- One clock, clk; rst is synchronous and active-high. All state updates on the rising edge of clk.
- Derived constants:
  - IN_BEATS = ceil(IN_WIDTH/LANES); OUT_BEATS = ceil(OUT_WIDTH/LANES)
  - IN_PAD = IN_BEATS*LANES; OUT_PAD = OUT_BEATS*LANES
  - Counter widths = clog2(beats+1).
- Reset values: word_o=0, word_o_valid=0, word_i_ready=1, test_o=0, test_frame_o=0, err_o=0. In-counter and out-counter are 0, shift registers are 0, out FSM is IDLE.
- Reset mid-frame discards the partial frame in either direction. There is no partial update of word_o.
- Input path (counter, no FSM):
  - On a cycle with test_valid_i=1, in_shreg (IN_PAD bits) shifts left by LANES with test_i into the LSBs, and in_cnt increments.
  - On the beat where in_cnt = IN_BEATS-1, the next word_o = low IN_WIDTH bits of the shifted value. word_o_valid pulses the following cycle, and in_cnt wraps to 0.
  - The first beat's bits therefore land at the MSBs; the top padding bits are dropped.
  - Input latency: word_o and word_o_valid appear 1 cycle after the last beat.
  - test_valid_i low: in_cnt and in_shreg hold. A frame may span any number of stalls.
- Output path FSM, states IDLE and SHIFT:
  - IDLE: word_i_ready=1, test_frame_o=0, test_o=0.
    - On word_i_valid=1, load out_shreg with zero-extended word_i, left-aligned so that bit OUT_WIDTH-1 sits at position OUT_PAD-1.
    - Set out_cnt=0, go to SHIFT, and drop word_i_ready on the next cycle.
  - SHIFT: test_o = top LANES bits of out_shreg (test_o[LANES-1] is the most significant) and test_frame_o=1.
    - Each cycle, shift left by LANES and increment out_cnt.
    - After OUT_BEATS beats, return to IDLE; word_i_ready=1 in that cycle.
  - word_i_valid while in SHIFT is ignored; there is no queueing.
  - Back-to-back frames: minimum one IDLE cycle between frames. Throughput is OUT_BEATS+1 cycles per word.
- The input and output paths are fully independent, so simultaneous events in both require no arbitration.

Optional Feature:
HARNESS_PARITY_EN:
- Defined:
  - Each frame in each direction carries one extra trailing beat: lane j carries the even parity of all bits that travelled on lane j during the frame.
  - Input: a mismatch sets err_o, which is sticky until rst. word_o still updates, but word_o_valid is suppressed for that frame.
  - Output: the parity beat is emitted with test_frame_o=1. The output frame is OUT_BEATS+1 beats.
- Undefined: no parity beat in either direction, and err_o is tied 0.

Decomposition:
- Shared package harness_pkg:
  - function clog2
  - function ceil_div
  - out-FSM state encoding (IDLE=1'b0, SHIFT=1'b1)
- One sub-module is natural: harness_lane_parity (per-lane running XOR accumulator with clear), instantiated twice when HARNESS_PARITY_EN is defined.

Test Plan:
- IN_WIDTH=8, LANES=1: drive bits 1,0,1,1,0,0,1,0 with test_valid_i=1 -> word_o=8'hB2 and word_o_valid pulses exactly 1 cycle after the 8th beat.
- IN_WIDTH=10, LANES=4: 3 beats 4'hF, 4'h5, 4'hA -> word_o=10'h35A (top 2 pad bits dropped).
- Same 8-bit frame with test_valid_i low for 3 cycles between beats 4 and 5 -> identical word_o=8'hB2 and one valid pulse.
- OUT_WIDTH=8, LANES=2, word_i=8'hC3, word_i_valid=1 -> test_o sequence 3,0,0,3 with test_frame_o high for 4 cycles; word_i_ready low for those 4 cycles; a word_i_valid pulse mid-frame is ignored.
- Assert rst at in-beat 5 of 8, then send a full 8'h5A frame -> word_o=8'h5A; no valid pulse before that frame completes.
- With HARNESS_PARITY_EN, LANES=1, 8'hB2 followed by parity bit 1 (wrong) -> err_o=1 and no word_o_valid pulse. Sending correct parity 0 after rst -> valid pulse and err_o=0.
